// File: rtl/uart_prog_loader_pkg.sv
// Shared encodings for the UART boot loader: loader FSM states, RX states, default frame header.
package uart_prog_loader_pkg;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_LEN_HI = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_CHK    = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_HDR    = ST_HDR,
        S_LEN_LO = ST_LEN_LO,
        S_LEN_HI = ST_LEN_HI,
        S_DATA   = ST_DATA,
        S_CHK    = ST_CHK,
        S_DONE   = ST_DONE,
        S_ERR    = ST_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte_valid with framing flag.
// Byte is reported one cycle after the stop bit is sampled at its midpoint.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_ferr_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          valid_q;
    logic [7:0]    data_q;
    logic          ferr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= sync_q[1];
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                // A true falling edge is required, so a low line left by a bad stop bit is not re-armed.
                RX_IDLE: begin
                    if (prev_q && !sync_q[1]) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync_q[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync_q[1], shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        data_q  <= shift_q;
                        ferr_q  <= !sync_q[1];
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign byte_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: holds the CPU, parses header/length/words/XOR checksum, writes program memory.
// One write strobe per received word, issued the cycle after its 4th byte; no back-pressure.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 2604,
    parameter int         ADDR_W       = 14,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              rx_i,
    output logic              prog_we_o,
    output logic [ADDR_W-1:0] prog_addr_o,
    output logic [31:0]       prog_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic       byte_vld;
    logic [7:0] byte_dat;
    logic       byte_ferr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .byte_valid_o (byte_vld),
        .byte_data_o  (byte_dat),
        .byte_ferr_o  (byte_ferr)
    );

    ld_state_t         state_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       rem_q;
    logic [1:0]        bcnt_q;
    logic [31:0]       word_q;
    logic [7:0]        chk_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [15:0] len_w;
    logic [31:0] word_w;
    assign len_w  = {byte_dat, len_lo_q};
    assign word_w = {byte_dat, word_q[31:8]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            rem_q    <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            chk_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) addr_q <= addr_q + ADDR_W'(1);
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q <= S_HDR;
                        hold_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        chk_q   <= '0;
                        addr_q  <= '0;
                        bcnt_q  <= '0;
                    end
                end
                default: begin
                    if (byte_vld && byte_ferr) begin
                        state_q <= S_ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (byte_vld) begin
                        case (state_q)
                            S_HDR: begin
                                if (byte_dat == HDR_BYTE) state_q <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                len_lo_q <= byte_dat;
                                chk_q    <= chk_q ^ byte_dat;
                                state_q  <= S_LEN_HI;
                            end
                            S_LEN_HI: begin
                                chk_q  <= chk_q ^ byte_dat;
                                rem_q  <= len_w;
                                bcnt_q <= '0;
                                if (len_w == 16'd0) begin
                                    state_q <= S_CHK;
                                end else if ({1'b0, len_w} > MAX_WORDS) begin
                                    state_q <= S_ERR;
                                    busy_q  <= 1'b0;
                                    err_q   <= 1'b1;
                                end else begin
                                    state_q <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                chk_q  <= chk_q ^ byte_dat;
                                word_q <= word_w;
                                bcnt_q <= bcnt_q + 2'd1;
                                if (bcnt_q == 2'd3) begin
                                    we_q    <= 1'b1;
                                    wdata_q <= word_w;
                                    rem_q   <= rem_q - 16'd1;
                                    if (rem_q == 16'd1) state_q <= S_CHK;
                                end
                            end
                            S_CHK: begin
                                busy_q <= 1'b0;
                                if (byte_dat == chk_q) begin
                                    state_q <= S_DONE;
                                    hold_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= S_ERR;
                                    err_q   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign prog_we_o    = we_q;
    assign prog_addr_o  = addr_q;
    assign prog_wdata_o = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: drives UART frames, scores writes and final status against a frame model.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int CPB = 8;
    localparam int AW  = 4;

    typedef logic [7:0] u8_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          rx = 1'b1;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_wdata;
    logic          cpu_hold, busy, done, err;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .HDR_BYTE(8'hA5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .rx_i         (rx),
        .prog_we_o    (prog_we),
        .prog_addr_o  (prog_addr),
        .prog_wdata_o (prog_wdata),
        .cpu_hold_o   (cpu_hold),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    wr_t  exp_q[$];
    wr_t  log_q[$];
    logic exp_done, exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    // Every cycle: status coherence, and each write strobe against the model's expected write list.
    wr_t w_exp;
    always @(negedge clk) begin
        if (!rst) begin
            check("status_coherent", 64'({cpu_hold, done & err}), 64'({busy | err, 1'b0}));
            if (prog_we) begin
                log_q.push_back({prog_addr, prog_wdata});
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(1), 64'(0));
                end else begin
                    w_exp = exp_q.pop_front();
                    check("wr_addr", 64'(prog_addr), 64'(w_exp.addr));
                    check("wr_data", 64'(prog_wdata), 64'(w_exp.data));
                end
            end
        end
    end

    // Frame model: find header, read length, assemble words, XOR checksum; a framing error truncates.
    task automatic model_frame(input u8_t b[$], input int ferr_at);
        int p, n, q;
        u8_t x;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        p = 0;
        while (p < b.size() && b[p] != HDR_BYTE_DEF) p++;
        if (ferr_at >= 0 && ferr_at <= p + 2) begin exp_err = 1'b1; return; end
        n = int'({b[p+2], b[p+1]});
        x = b[p+1] ^ b[p+2];
        if (n > (1 << AW)) begin exp_err = 1'b1; return; end
        for (int k = 0; k < n; k++) begin
            q = p + 3 + 4 * k;
            if (ferr_at >= 0 && ferr_at <= q + 3) begin exp_err = 1'b1; return; end
            exp_q.push_back({AW'(k), b[q+3], b[q+2], b[q+1], b[q]});
            x = x ^ b[q] ^ b[q+1] ^ b[q+2] ^ b[q+3];
        end
        exp_done = (b[p + 3 + 4 * n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input u8_t b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic glitch();
        @(negedge clk) rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input u8_t b[$], input int ferr_at, input int start_at, input int glitch_at);
        for (int i = 0; i < b.size(); i++) begin
            if (i == start_at) pulse_start();
            if (i == glitch_at) glitch();
            send_byte(b[i], i != ferr_at);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_case(input string name, input u8_t b[$], input int ferr_at,
                            input int start_at, input int glitch_at);
        log_q.delete();
        model_frame(b, ferr_at);
        pulse_start();
        send_frame(b, ferr_at, start_at, glitch_at);
        check({name, "_done"}, 64'(done), 64'(exp_done));
        check({name, "_err"}, 64'(err), 64'(exp_err));
        check({name, "_hold"}, 64'(cpu_hold), 64'(!exp_done));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_writes_left"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"}, 64'(prog_we), 64'(0));
        check({name, "_addr"}, 64'(prog_addr), 64'(0));
        check({name, "_wdata"}, 64'(prog_wdata), 64'(0));
        check({name, "_hold"}, 64'(cpu_hold), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_done"}, 64'(done), 64'(0));
        check({name, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        u8_t f1[$], f2[$], f3[$], f4[$], f5[$], f6[$], f7[$], f8[$], f9[$];
        f1 = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        f2 = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
        f3 = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h05};
        f4 = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
        f5 = '{8'hA5, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h05};
        f6 = '{8'hA5, 8'h00, 8'h00, 8'h00};
        f7 = '{8'hA5, 8'h11, 8'h00};
        f8 = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        f9 = '{8'hA5, 8'h10, 8'h00};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: two-word good frame
        run_case("t1", f1, -1, -1, -1);
        check("t1_model_done", 64'(exp_done), 64'(1));
        check("t1_nwrites", 64'(log_q.size()), 64'(2));
        if (log_q.size() == 2) begin
            check("t1_w0", 64'(log_q[0]), 64'({4'h0, 32'h12345678}));
            check("t1_w1", 64'(log_q[1]), 64'({4'h1, 32'hDEADBEEF}));
        end

        // 2: bad checksum, words still written
        run_case("t2", f2, -1, -1, -1);
        check("t2_model_err", 64'(exp_err), 64'(1));
        check("t2_nwrites", 64'(log_q.size()), 64'(2));

        // 3: junk before header
        run_case("t3", f3, -1, -1, -1);
        check("t3_w0", 64'(log_q.size() > 0 ? log_q[0] : '0), 64'({4'h0, 32'h01020304}));

        // 4: framing error on 2nd data byte; glitches in HDR and LEN_LO
        run_case("t4_ferr", f4, 4, -1, -1);
        check("t4_nwrites", 64'(log_q.size()), 64'(0));
        run_case("t4_glitch_hdr", f5, -1, -1, 0);
        run_case("t4_glitch_len", f5, -1, -1, 1);
        check("t4_glitch_done", 64'(done), 64'(1));

        // 5: zero length; length one past capacity; length exactly capacity accepted
        run_case("t5_zero", f6, -1, -1, -1);
        check("t5_zero_nwrites", 64'(log_q.size()), 64'(0));
        run_case("t5_over", f7, -1, -1, -1);
        check("t5_over_err", 64'(err), 64'(1));
        pulse_start();
        send_frame(f9, -1, -1, -1);
        check("t5_cap_busy", 64'(busy), 64'(1));
        check("t5_cap_err", 64'(err), 64'(0));

        // 6: reset mid-DATA, then clean reload, then start pulsed mid-load
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56}, -1, -1, -1);
        check("t6_mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_case("t6_reload", f8, -1, -1, -1);
        check("t6_reload_w0", 64'(log_q.size() > 0 ? log_q[0] : '0), 64'({4'h0, 32'hDEADBEEF}));
        run_case("t6_start_mid", f1, -1, 5, -1);
        check("t6_start_mid_done", 64'(done), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
